uart_tx_fifo_param: RTL and testbench



---
 rtl/vm16_uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo_param.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm16_uart_pkg.sv
// Shared definitions for the vmicro16 UART blocks.
//   tx_state_e  : transmitter frame FSM encoding
//   PARITY_*    : values accepted by the PARITY parameter
//   parity_of() : parity bit of a data word (zero-extended to 9 bits)
package vm16_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Zero padding above DATA_W does not change the XOR, so one 9-bit
    // helper covers every legal data width.
    function automatic logic parity_of(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO shared by the UART TX and RX paths.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty); dout shows the head word
//   full,empty : flags decoded from the registered occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter. Words written through wr_en are queued and sent
// LSB-first as start / data / optional parity / stop bits, one bit per clken.
//   clk_50m, rst_n : system clock, asynchronous active-low reset
//   clken          : baud tick, one pulse per bit period
//   din, wr_en     : word to queue and its write strobe
//   tx             : serial line, idle high
//   tx_busy        : frame in progress or words queued
//   full, empty    : FIFO flags
//   overflow       : one-cycle pulse after a write attempted while full
module uart_tx_fifo_param
    import vm16_uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              clken,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int BW = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [BW-1:0]     bitpos_q, bitpos_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;

    logic              start_frame;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (start_frame),
        .din   (din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        bitpos_d    = bitpos_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        overflow_d  = wr_en && fifo_full;

        if (clken) begin
            case (state_q)
                ST_IDLE: begin
                    tx_d        = 1'b1;
                    start_frame = !fifo_empty;
                end
                ST_START: begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitpos_d = BW'(1);
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    // bitpos counts data bits already on the line.
                    if (bitpos_q != BW'(DATA_W)) begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitpos_d = bitpos_q + BW'(1);
                    end else if (PARITY != PARITY_NONE) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        // End of the last stop bit: chain straight into the next frame if queued.
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tx_d   = 1'b1;
                        stop_d = 1'b1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Pop and start bit share one tick; parity is captured before the word is shifted out.
        if (start_frame) begin
            tx_d     = 1'b0;
            shift_d  = fifo_dout;
            par_d    = parity_of(9'(fifo_dout), PARITY);
            bitpos_d = '0;
            state_d  = ST_START;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bitpos_q   <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitpos_q   <= bitpos_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: a default-configured instance checked every
// cycle against a queue-based line model, plus a 7-bit / odd-parity /
// two-stop instance checked through a table of expected frame bit strings.
module tb_uart_tx_fifo_param;

    localparam int W1 = 8, P1 = 0, S1 = 1, DEPTH1 = 4;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clken   = 1'b0;
    logic       wr_en   = 1'b0;
    logic       wr_en2  = 1'b0;
    logic [7:0] din     = '0;
    logic [6:0] din2    = '0;
    logic       tx, tx_busy, full, empty, overflow;
    logic       tx2, tx_busy2, full2, empty2, overflow2;

    always #5 clk_50m = ~clk_50m;

    uart_tx_fifo_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) dut (
        .clk_50m (clk_50m), .rst_n (rst_n), .clken (clken), .din (din), .wr_en (wr_en),
        .tx (tx), .tx_busy (tx_busy), .full (full), .empty (empty), .overflow (overflow)
    );

    uart_tx_fifo_param #(.DATA_W(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(2)) dut2 (
        .clk_50m (clk_50m), .rst_n (rst_n), .clken (clken), .din (din2), .wr_en (wr_en2),
        .tx (tx2), .tx_busy (tx_busy2), .full (full2), .empty (empty2), .overflow (overflow2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud tick generator: one pulse every ck_div cycles (ck_div=1 holds it high).
    int ck_div = 16;
    int ck_cnt = 0;
    initial forever begin
        @(posedge clk_50m);
        #1;
        ck_cnt = (ck_cnt + 1 >= ck_div) ? 0 : ck_cnt + 1;
        clken  = (ck_cnt == 0);
    end

    // Line model for dut: a queue of accepted words and a queue of frame bits still to send.
    logic [7:0] m_words[$];
    bit         m_frame[$];
    bit         m_in_frame = 1'b0;
    bit         m_tx       = 1'b1;
    bit         m_ovf      = 1'b0;
    bit         m_was_full;

    task automatic build_frame(input logic [7:0] w);
        bit p;
        p = 1'b0;
        m_frame.push_back(1'b0);
        for (int i = 0; i < W1; i++) begin
            m_frame.push_back(w[i]);
            p ^= w[i];
        end
        if (P1 != 0) m_frame.push_back((P1 == 2) ? !p : p);
        for (int s = 0; s < S1; s++) m_frame.push_back(1'b1);
    endtask

    initial forever begin
        @(posedge clk_50m or negedge rst_n);
        if (!rst_n) begin
            m_words.delete();
            m_frame.delete();
            m_in_frame = 1'b0;
            m_tx       = 1'b1;
            m_ovf      = 1'b0;
        end else begin
            m_was_full = (m_words.size() == DEPTH1);
            m_ovf      = wr_en && m_was_full;
            if (clken) begin
                if (m_frame.size() == 0 && m_words.size() != 0) build_frame(m_words.pop_front());
                if (m_frame.size() != 0) begin
                    m_tx       = m_frame.pop_front();
                    m_in_frame = 1'b1;
                end else begin
                    m_tx       = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
            if (wr_en && !m_was_full) m_words.push_back(din);
        end
    end

    // Compare dut against the model mid-cycle, away from the active edge.
    initial forever begin
        @(negedge clk_50m);
        check("tx", tx, m_tx);
        check("tx_busy", tx_busy, m_in_frame || (m_words.size() != 0));
        check("full", full, m_words.size() == DEPTH1);
        check("empty", empty, m_words.size() == 0);
        check("overflow", overflow, m_ovf);
    end

    // Waits for the next edge on which clken is sampled high, then steps #1 past it.
    task automatic wait_tick();
        int b;
        b = 0;
        do begin
            @(posedge clk_50m);
            b++;
        end while (!clken && b < 200);
        if (!clken) check("tick_timeout", clken, 1'b1);
        #1;
    endtask

    typedef struct {
        logic        sel2;
        int          n;
        logic [23:0] words;
        string       bits;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        wait_tick();
        for (int i = 0; i < v.n; i++) begin
            @(posedge clk_50m);
            #1;
            if (v.sel2) begin
                wr_en2 = 1'b1;
                din2   = v.words[8*i +: 7];
            end else begin
                wr_en  = 1'b1;
                din    = v.words[8*i +: 8];
            end
        end
        @(posedge clk_50m);
        #1;
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
        for (int k = 0; k < v.bits.len(); k++) begin
            wait_tick();
            check($sformatf("frame_%0h_bit%0d", v.words, k), v.sel2 ? tx2 : tx, v.bits[k] == 8'h31);
        end
        wait_tick();
        check("idle_tx_after_frame", v.sel2 ? tx2 : tx, 1'b1);
        check("idle_busy_after_frame", v.sel2 ? tx_busy2 : tx_busy, 1'b0);
    endtask

    int ticks;

    initial begin
        vecs[0] = '{1'b0, 1, 24'h0000A5, "0101001011"};
        vecs[1] = '{1'b0, 3, 24'h55FF00, "000000000101111111110101010101"};
        vecs[2] = '{1'b1, 1, 24'h000041, "01000001111"};
        vecs[3] = '{1'b1, 1, 24'h00007F, "01111111011"};
        vecs[4] = '{1'b1, 1, 24'h000000, "00000000111"};
        vecs[5] = '{1'b0, 1, 24'h000081, "0100000011"};

        // Reset values of both instances.
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        check("rst_tx2", tx2, 1'b1);
        check("rst_busy2", tx_busy2, 1'b0);
        check("rst_full2", full2, 1'b0);
        check("rst_empty2", empty2, 1'b1);
        check("rst_ovf2", overflow2, 1'b0);
        rst_n = 1'b1;

        // Idle with a tick every 16 cycles.
        ck_div = 16;
        repeat (64) @(posedge clk_50m);
        #1;
        check("idle_tx", tx, 1'b1);
        check("idle_busy", tx_busy, 1'b0);
        check("idle_empty", empty, 1'b1);

        // Table-driven frames, including back-to-back words and the 7O2 instance.
        ck_div = 8;
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Overflow: one frame in flight, then six writes into a 4-deep FIFO.
        ck_div = 16;
        wait_tick();
        @(posedge clk_50m);
        #1;
        wr_en = 1'b1;
        din   = 8'h11;
        @(posedge clk_50m);
        #1;
        wr_en = 1'b0;
        wait_tick();
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk_50m);
            #1;
            if (i >= 1) check($sformatf("ovf_seq_%0d", i), overflow, i >= 5);
            if (i >= 1) check($sformatf("full_seq_%0d", i), full, i >= 4);
            wr_en = (i < 6);
            din   = 8'hC0 + 8'(i);
        end
        wr_en = 1'b0;
        // First frame (started one tick earlier) plus four queued frames: 50 ticks to idle.
        ticks = 0;
        while (tx_busy && ticks < 100) begin
            wait_tick();
            ticks++;
        end
        check("drain_ticks", ticks, 50);

        // Reset in the middle of the data bits of 0x3C with another word queued.
        ck_div = 8;
        wait_tick();
        @(posedge clk_50m);
        #1;
        wr_en = 1'b1;
        din   = 8'h3C;
        @(posedge clk_50m);
        #1;
        din   = 8'h99;
        @(posedge clk_50m);
        #1;
        wr_en = 1'b0;
        repeat (4) wait_tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_empty", empty, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        repeat (2) @(posedge clk_50m);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_50m);
        #1;
        check("postrst_tx", tx, 1'b1);
        run_vec(vecs[5]);

        // Random traffic at varying tick rates, including clken held high.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_50m);
            #1;
            if (c % 250 == 0) ck_div = $urandom_range(1, 5);
            wr_en = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
        end
        wr_en  = 1'b0;
        ck_div = 2;
        ticks  = 0;
        while (tx_busy && ticks < 5000) begin
            @(posedge clk_50m);
            ticks++;
        end
        #1;
        check("final_drain_busy", tx_busy, 1'b0);
        check("final_drain_tx", tx, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
